// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO output block: register offsets (address[4:2]) and reset values.
package gpio_pkg;

  localparam logic [2:0] GPIO_OFS_OUT    = 3'd0;
  localparam logic [2:0] GPIO_OFS_MASK   = 3'd1;
  localparam logic [2:0] GPIO_OFS_PERIOD = 3'd2;
  localparam logic [2:0] GPIO_OFS_STATUS = 3'd3;
  localparam logic [2:0] GPIO_OFS_DUTY   = 3'd4;

  localparam logic [23:0] GPIO_PERIOD_RST = 24'd5000000;
  localparam logic [7:0]  GPIO_DUTY_RST   = 8'hFF;
  localparam int unsigned GPIO_NUM_LEDS   = 6;

endpackage

// File: rtl/led_output_module_if.sv
// GPIO bus carrying the CPU-side strobes, address and data for the LED output block.
interface led_output_module_if;
  logic        wen;
  logic        ren;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output wen, ren, address, data_in, input data_out);
  modport slave  (input wen, ren, address, data_in, output data_out);
endinterface

// File: rtl/blink_prescaler.sv
// Blink prescaler: counts clk cycles up to the programmed half-period and toggles the phase.
module blink_prescaler #(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PERIOD_W-1:0] period,
    input  logic                period_wr,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + PERIOD_W'(1);
        phase_d = phase_q;
        if (period_wr) begin
            // A new period restarts the count but keeps the current phase.
            cnt_d = '0;
        end else if (period == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period - PERIOD_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/led_output_module.sv
// Memory-mapped LED output block with per-LED blink mask and programmable blink period.
// Optional global brightness PWM (DUTY register) is built when LED_PWM_EN is defined.
module led_output_module
    import gpio_pkg::*;
#(
    parameter int unsigned         NUM_LEDS   = GPIO_NUM_LEDS,
    parameter int unsigned         PERIOD_W   = 24,
    parameter logic [PERIOD_W-1:0] PERIOD_RST = GPIO_PERIOD_RST
) (
    input  logic                clk,
    input  logic                rst,
    led_output_module_if.slave  bus,
    output logic [NUM_LEDS-1:0] leds
);

    logic [2:0]          ofs;
    logic [NUM_LEDS-1:0] out_q, mask_q, leds_q;
    logic [PERIOD_W-1:0] period_q;
    logic [31:0]         rdata, data_out_q;
    logic                wr_out, wr_mask, wr_period;
    logic                phase, pwm_on;
    logic                unused_bits;

    assign ofs         = bus.address[4:2];
    assign unused_bits = ^{bus.address[31:5], bus.address[1:0], bus.data_in};

    assign wr_out    = bus.wen && (ofs == GPIO_OFS_OUT);
    assign wr_mask   = bus.wen && (ofs == GPIO_OFS_MASK);
    assign wr_period = bus.wen && (ofs == GPIO_OFS_PERIOD);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            mask_q   <= '0;
            period_q <= PERIOD_RST;
        end else begin
            if (wr_out)    out_q    <= bus.data_in[NUM_LEDS-1:0];
            if (wr_mask)   mask_q   <= bus.data_in[NUM_LEDS-1:0];
            if (wr_period) period_q <= bus.data_in[PERIOD_W-1:0];
        end
    end

    blink_prescaler #(
        .PERIOD_W (PERIOD_W)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .period    (period_q),
        .period_wr (wr_period),
        .phase     (phase)
    );

`ifdef LED_PWM_EN
    logic [7:0] duty_q, pwm_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q    <= GPIO_DUTY_RST;
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            if (bus.wen && (ofs == GPIO_OFS_DUTY)) duty_q <= bus.data_in[7:0];
        end
    end

    // Full-scale duty must never blank, even on the one cycle where pwm_cnt == 8'hFF.
    assign pwm_on = (duty_q == 8'hFF) | (pwm_cnt_q < duty_q);
`else
    assign pwm_on = 1'b1;
`endif

    // Reads sample the registers before any same-cycle write lands.
    always_comb begin
        rdata = '0;
        case (ofs)
            GPIO_OFS_OUT:    rdata[NUM_LEDS-1:0] = out_q;
            GPIO_OFS_MASK:   rdata[NUM_LEDS-1:0] = mask_q;
            GPIO_OFS_PERIOD: rdata[PERIOD_W-1:0] = period_q;
            GPIO_OFS_STATUS: rdata[0]            = phase;
`ifdef LED_PWM_EN
            GPIO_OFS_DUTY:   rdata[7:0]          = duty_q;
`endif
            default:         rdata               = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
            leds_q     <= '0;
        end else begin
            if (bus.ren) data_out_q <= rdata;
            leds_q <= out_q & ~(mask_q & {NUM_LEDS{phase}}) & {NUM_LEDS{pwm_on}};
        end
    end

    assign bus.data_out = data_out_q;
    assign leds         = leds_q;

endmodule

// File: tb/tb_led_output_module.sv
// Self-checking bench for led_output_module: register table, blink timing, boundaries, reset, PWM.
module tb_led_output_module;
    import gpio_pkg::*;

    logic       clk;
    logic       rst;
    logic [5:0] leds;
    int         tests;
    int         fails;

    led_output_module_if bus ();

    led_output_module dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .leds (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  ofs;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [31:0] exp_leds;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] ofs, input logic [31:0] d);
        bus.address = {27'd0, ofs, 2'b00};
        bus.data_in = d;
        bus.wen     = 1'b1;
        tick();
        bus.wen     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] ofs, output logic [31:0] d);
        bus.address = {27'd0, ofs, 2'b00};
        bus.ren     = 1'b1;
        tick();
        bus.ren     = 1'b0;
        d           = bus.data_out;
    endtask

    task automatic watch_status();
        bus.address = {27'd0, GPIO_OFS_STATUS, 2'b00};
        bus.ren     = 1'b1;
    endtask

    logic [31:0] d;
    logic [31:0] exp_l;
    logic        found;
    int          lit;

    initial begin
        tests = 0;
        fails = 0;
        vecs[0]  = '{GPIO_OFS_OUT,    32'hFFFF_FFFF, 32'h0000_003F, 32'h3F};
        vecs[1]  = '{GPIO_OFS_OUT,    32'h0000_0015, 32'h0000_0015, 32'h15};
        vecs[2]  = '{GPIO_OFS_OUT,    32'hFFFF_FFC0, 32'h0000_0000, 32'h00};
        vecs[3]  = '{GPIO_OFS_MASK,   32'hFFFF_FFFF, 32'h0000_003F, 32'h00};
        vecs[4]  = '{GPIO_OFS_OUT,    32'h0000_002A, 32'h0000_002A, 32'h2A};
        vecs[5]  = '{GPIO_OFS_MASK,   32'h0000_0000, 32'h0000_0000, 32'h2A};
        vecs[6]  = '{GPIO_OFS_PERIOD, 32'hFFFF_FFFF, 32'h00FF_FFFF, 32'h2A};
        vecs[7]  = '{GPIO_OFS_PERIOD, 32'hAB12_3456, 32'h0012_3456, 32'h2A};
        vecs[8]  = '{GPIO_OFS_STATUS, 32'hFFFF_FFFF, 32'h0000_0000, 32'h2A};
        vecs[9]  = '{3'd5,            32'hFFFF_FFFF, 32'h0000_0000, 32'h2A};
        vecs[10] = '{3'd7,            32'h1234_5678, 32'h0000_0000, 32'h2A};
`ifdef LED_PWM_EN
        vecs[11] = '{GPIO_OFS_DUTY,   32'hFFFF_FFFF, 32'h0000_00FF, 32'h2A};
`else
        vecs[11] = '{GPIO_OFS_DUTY,   32'hFFFF_FFFF, 32'h0000_0000, 32'h2A};
`endif

        bus.wen = 1'b0;
        bus.ren = 1'b0;
        bus.address = '0;
        bus.data_in = '0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_data_out", bus.data_out, 32'h0);
        rst = 1'b0;
        rd(GPIO_OFS_PERIOD, d);
        check("rst_period", d, 32'd5000000);
        rd(GPIO_OFS_DUTY, d);
`ifdef LED_PWM_EN
        check("rst_duty", d, 32'h0000_00FF);
`else
        check("rst_ofs4_unmapped", d, 32'h0);
`endif

        // Write, read back, and leds two edges after the write.
        for (int i = 0; i < 12; i++) begin
            wr(vecs[i].ofs, vecs[i].wdata);
            rd(vecs[i].ofs, d);
            check($sformatf("vec%0d_read", i), d, vecs[i].exp_rd);
            check($sformatf("vec%0d_leds", i), 32'(leds), vecs[i].exp_leds);
        end

        // Blink with half-period 4: masked LEDs 1:0 blank every other 4 cycles.
        wr(GPIO_OFS_PERIOD, 32'd4);
        wr(GPIO_OFS_OUT, 32'h3F);
        wr(GPIO_OFS_MASK, 32'h03);
        watch_status();
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (leds == 6'h3C) found = 1'b1;
        end
        check("blink_sync", 32'(found), 32'd1);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick();
            exp_l = (((k / 4) % 2) == 0) ? 32'h3C : 32'h3F;
            check($sformatf("blink_leds_k%0d", k), 32'(leds), exp_l);
            check($sformatf("blink_status_k%0d", k), 32'(bus.data_out[0]),
                  (exp_l == 32'h3C) ? 32'd1 : 32'd0);
        end
        bus.ren = 1'b0;

        // PERIOD = 0 freezes phase at 0.
        wr(GPIO_OFS_PERIOD, 32'd0);
        watch_status();
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            check("p0_leds", 32'(leds), 32'h3F);
            check("p0_status", bus.data_out, 32'h0);
        end
        bus.ren = 1'b0;

        // PERIOD = 1 toggles phase every cycle.
        wr(GPIO_OFS_PERIOD, 32'd1);
        watch_status();
        tick();
        exp_l = 32'h3F;
        check("p1_first", 32'(leds), exp_l);
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_l = (exp_l == 32'h3F) ? 32'h3C : 32'h3F;
            check($sformatf("p1_leds_k%0d", k), 32'(leds), exp_l);
            check($sformatf("p1_status_k%0d", k), 32'(bus.data_out[0]),
                  (exp_l == 32'h3C) ? 32'd1 : 32'd0);
        end
        bus.ren = 1'b0;

        // Same-cycle read and write of OUT returns the old value.
        wr(GPIO_OFS_PERIOD, 32'd0);
        tick();
        bus.address = {27'd0, GPIO_OFS_OUT, 2'b00};
        bus.data_in = 32'h15;
        bus.wen = 1'b1;
        bus.ren = 1'b1;
        tick();
        bus.wen = 1'b0;
        bus.ren = 1'b0;
        check("rw_same_old", bus.data_out, 32'h3F);
        rd(GPIO_OFS_OUT, d);
        check("rw_same_new", d, 32'h15);
        check("rw_same_leds", 32'(leds), 32'h15);

        // Reset while phase = 1, with a write and read in flight.
        wr(GPIO_OFS_OUT, 32'h3F);
        wr(GPIO_OFS_PERIOD, 32'd8);
        watch_status();
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            tick();
            if (leds == 6'h3C) found = 1'b1;
        end
        check("rst_mid_sync", 32'(found), 32'd1);
        rst = 1'b1;
        bus.address = {27'd0, GPIO_OFS_OUT, 2'b00};
        bus.data_in = 32'h2A;
        bus.wen = 1'b1;
        bus.ren = 1'b1;
        tick();
        rst = 1'b0;
        bus.wen = 1'b0;
        bus.ren = 1'b0;
        check("rst_mid_leds", 32'(leds), 32'h0);
        check("rst_mid_data_out", bus.data_out, 32'h0);
        rd(GPIO_OFS_STATUS, d);
        check("rst_mid_phase", d, 32'h0);
        rd(GPIO_OFS_PERIOD, d);
        check("rst_mid_period", d, 32'd5000000);
        rd(GPIO_OFS_OUT, d);
        check("rst_mid_out", d, 32'h0);
        rd(GPIO_OFS_MASK, d);
        check("rst_mid_mask", d, 32'h0);
        check("rst_mid_leds2", 32'(leds), 32'h0);

`ifdef LED_PWM_EN
        wr(GPIO_OFS_OUT, 32'h3F);
        for (int j = 0; j < 3; j++) begin
            case (j)
                0: wr(GPIO_OFS_DUTY, 32'd64);
                1: wr(GPIO_OFS_DUTY, 32'd0);
                default: wr(GPIO_OFS_DUTY, 32'd255);
            endcase
            tick();
            tick();
            lit = 0;
            for (int c = 0; c < 256; c++) begin
                tick();
                if (leds == 6'h3F) lit++;
            end
            check($sformatf("pwm_lit_j%0d", j), 32'(lit),
                  (j == 0) ? 32'd64 : ((j == 1) ? 32'd0 : 32'd256));
        end
`else
        wr(GPIO_OFS_DUTY, 32'd64);
        rd(GPIO_OFS_DUTY, d);
        check("nopwm_ofs4_read", d, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
